drum_mac_accumulator: RTL

Pipelined multiply-accumulate stage for the approximate CNN datapath. It accepts a stream of signed activation/weight pairs and forms each product with a `DRUMk_M_N_s` instance. Products are accumulated over a window whose end is marked by `in_last`. Each completed window is emitted as one requantized, saturated result through a valid/ready output register that feeds the activation/pooling stage.

---
 rtl/drum_mac_accumulator.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/drum_mac_accumulator.sv
// Pipelined DRUM multiply-accumulate stage: S1 operand register, S2 product
// register, S3 window accumulator with requantizing valid/ready output register.
module drum_mac_accumulator #(
    parameter int K     = 6,
    parameter int N     = 16,
    parameter int M     = 16,
    parameter int ACC_W = 40,
    parameter int OUT_W = 32,
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [M-1:0]     in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic [15:0]      out_count
);

    localparam int P_W = N + M;

    localparam logic signed [ACC_W-1:0] T_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] T_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic                    stall;
    logic                    s1_v;
    logic                    s1_last;
    logic [N-1:0]            s1_a;
    logic [M-1:0]            s1_b;
    logic                    s2_v;
    logic                    s2_last;
    logic signed [ACC_W-1:0] s2_prod;
    logic [P_W-1:0]          prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] t;
    logic [15:0]             cnt;
    logic [15:0]             cnt_inc;
    logic [OUT_W-1:0]        q_data;
    logic                    q_sat;
    logic                    close_win;

    // Only a closing product can be blocked by an occupied output register.
    assign stall     = out_valid && !out_ready && s2_v && s2_last;
    assign in_ready  = !stall;
    assign close_win = !stall && s2_v && s2_last;

    DRUMk_M_N_s #(
        .K (K),
        .M (N),
        .N (M)
    ) u_drum (
        .a (s1_a),
        .b (s1_b),
        .r (prod)
    );

    assign sum     = acc + s2_prod;
    assign t       = sum >>> SHIFT;
    assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

    always_comb begin
        q_data = t[OUT_W-1:0];
        q_sat  = 1'b0;
        if (t > T_MAX) begin
            q_data = {1'b0, {(OUT_W-1){1'b1}}};
            q_sat  = 1'b1;
        end else if (t < T_MIN) begin
            q_data = {1'b1, {(OUT_W-1){1'b0}}};
            q_sat  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_last <= 1'b0;
            s1_a    <= '0;
            s1_b    <= '0;
            s2_v    <= 1'b0;
            s2_last <= 1'b0;
            s2_prod <= '0;
        end else if (!stall) begin
            s1_v    <= in_valid;
            s1_last <= in_last;
            s1_a    <= in_a;
            s1_b    <= in_b;
            s2_v    <= s1_v;
            s2_last <= s1_last;
            s2_prod <= ACC_W'($signed(prod));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (!stall && s2_v) begin
            if (s2_last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_count <= '0;
        end else if (close_win) begin
            out_valid <= 1'b1;
            out_data  <= q_data;
            out_sat   <= q_sat;
            out_count <= cnt_inc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// Signed DRUM multiplier: one's-complement magnitudes, each truncated to K
// significant bits with the dropped tail replaced by a forced LSB of one.
module DRUMk_M_N_s #(
    parameter int K = 6,
    parameter int M = 16,
    parameter int N = 16
) (
    input  logic [M-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [M+N-1:0] r
);

    localparam int R_W = M + N;

    logic [M-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [K-1:0]   a_t;
    logic [K-1:0]   b_t;
    int             a_sh;
    int             b_sh;
    logic [R_W-1:0] r_mag;

    assign a_mag = a[M-1] ? ~a : a;
    assign b_mag = b[N-1] ? ~b : b;

    // Ascending scan: the highest set bit above the K-bit window wins.
    always_comb begin
        a_t  = a_mag[K-1:0];
        a_sh = 0;
        for (int i = K; i < M; i++) begin
            if (a_mag[i]) begin
                a_sh   = i - K + 1;
                a_t    = K'(a_mag >> (i - K + 1));
                a_t[0] = 1'b1;
            end
        end
    end

    always_comb begin
        b_t  = b_mag[K-1:0];
        b_sh = 0;
        for (int i = K; i < N; i++) begin
            if (b_mag[i]) begin
                b_sh   = i - K + 1;
                b_t    = K'(b_mag >> (i - K + 1));
                b_t[0] = 1'b1;
            end
        end
    end

    assign r_mag = (R_W'(a_t) * R_W'(b_t)) << (a_sh + b_sh);
    assign r     = (a[M-1] ^ b[N-1]) ? ~r_mag : r_mag;

endmodule
